// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong game-flow and score overlay logic.
package pong_pkg;

  localparam int unsigned DEF_NUM_BALLS   = 3;
  localparam int unsigned DEF_HOLD_FRAMES = 120;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } game_state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_score_t;

  function automatic logic bcd_is_max(input bcd_score_t v);
    return (v.tens == 4'd9) && (v.units == 4'd9);
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit saturating BCD up-counter with synchronous clear and increment enable.
module bcd_counter2
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output bcd_score_t count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !bcd_is_max(count)) begin
      if (count.units == 4'd9) begin
        count.units <= 4'd0;
        count.tens  <= count.tens + 4'd1;
      end else begin
        count.units <= count.units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: serve/rally/pause/game-over flow, ball count, score and frame-paced pauses.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BALLS   = DEF_NUM_BALLS,
  parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       still,
  output logic [2:0] balls_left,
  output logic [7:0] score,
  output logic [1:0] game_state,
  output logic       game_over
);

  localparam int unsigned TW = $clog2(HOLD_FRAMES + 1);

  game_state_e state;
  logic [TW-1:0] timer;
  bcd_score_t    score_q;
  logic          score_clr;
  logic          score_inc;

  // Score clears on the OVER->NEWGAME transition; a simultaneous miss discards the hit.
  assign score_clr = (state == ST_OVER) && (timer == '0);
  assign score_inc = (state == ST_PLAY) && hit && !miss;

  bcd_counter2 u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (score_clr),
    .inc   (score_inc),
    .count (score_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_NEWGAME;
      timer      <= '0;
      balls_left <= 3'(NUM_BALLS);
      still      <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      case (state)
        ST_NEWGAME: begin
          if (btn != 2'b00) begin
            state <= ST_PLAY;
            still <= 1'b0;
          end
        end
        ST_PLAY: begin
          // Entering a pause loads the timer; a coincident refr_tick is not counted.
          if (miss) begin
            balls_left <= balls_left - 3'd1;
            timer      <= TW'(HOLD_FRAMES);
            still      <= 1'b1;
            if (balls_left == 3'd1) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_NEWBALL;
            end
          end
        end
        ST_NEWBALL: begin
          if (timer == '0) begin
            if (btn != 2'b00) begin
              state <= ST_PLAY;
              still <= 1'b0;
            end
          end else if (refr_tick) begin
            timer <= timer - TW'(1);
          end
        end
        ST_OVER: begin
          if (timer == '0) begin
            state      <= ST_NEWGAME;
            balls_left <= 3'(NUM_BALLS);
            game_over  <= 1'b0;
          end else if (refr_tick) begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= ST_NEWGAME;
      endcase
    end
  end

  assign game_state = state;
  assign score      = score_q;

endmodule
